pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised valid/ready pipeline stage register; next-generation replacement for the fixed
//  PC+4/IR inter-stage latch. Carries a DATA_W payload (default packs PC+4 and IR) and adds
//  back-pressure (stall) and a per-stage valid bit. Flush inserts a bubble of value FLUSH_VALUE.
//  Optional 2-entry skid buffer registers in_ready to break the combinational ready path.
// PARAMETERS
//  DATA_W       64     payload width in bits (default {pc_plus_4[31:0], ir[31:0]})
//  FLUSH_VALUE  '0     payload value loaded on reset/flush (bubble = NOP encoding)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous squash of all held entries (branch/jump redirect)
//  in_valid   in   1       upstream presents in_data
//  in_ready   out  1       stage accepts in_data this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a live instruction
//  out_ready  in   1       downstream consumes out_data this cycle (0 = stall)
//  out_data   out  DATA_W  payload to next stage
//  occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  - acc = in_valid & in_ready; pop = out_valid & out_ready; all updates on posedge clk.
//  - Priority: reset > flush > normal operation.
//  - Reset: state EMPTY, out_valid=0, out_data=FLUSH_VALUE, skid data=FLUSH_VALUE, occupancy=0,
//    in_ready=1 from the first cycle after reset.
//  - Flush: next state EMPTY, out_valid=0, out_data and skid <= FLUSH_VALUE, occupancy=0.
//    A word accepted (acc=1) in a flush cycle is discarded; a pop in a flush cycle still
//    completes downstream (downstream sees that cycle's out_data).
//  - Payload is only loaded on acc; no out_data change while out_valid=1 & out_ready=0.
//  - Latency: 1 cycle from acc to out_valid when EMPTY; throughput 1 word/cycle when
//    out_ready held high. Ordering strictly FIFO; no word lost or duplicated.
//  - States (with skid): EMPTY(occ 0), ONE(occ 1, main valid), TWO(occ 2, main+skid valid).
//    EMPTY: acc -> ONE, main<=in_data.
//    ONE:   acc&pop -> ONE, main<=in_data; acc&!pop -> TWO, skid<=in_data;
//           !acc&pop -> EMPTY; else hold.
//    TWO:   pop -> ONE, main<=skid; else hold. in_ready=0 in TWO, so no acc.
//  - in_ready is a registered output: 1 in EMPTY/ONE, 0 in TWO; no in->out comb path.
//  - out_valid = (state != EMPTY); out_data = main register.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: 3-state skid behaviour above, occupancy 0..2, registered in_ready.
//  PIPE_STAGE_SKID_EN undefined: single entry, states EMPTY/ONE only, skid register absent,
//    in_ready = !out_valid | out_ready (combinational), acc&!pop in ONE impossible,
//    occupancy never exceeds 1. Reset/flush rules unchanged.
// STRUCTURE
//  - Shared package pipe_pkg: state enum {ST_EMPTY, ST_ONE, ST_TWO}; if_id_payload_t struct
//    {pc_plus_4[31:0], ir[31:0]}; NOP_INSN constant used as FLUSH_VALUE by the IF/ID instance.
//  - Single module, no sub-module; skid slot is one register plus mux, not worth splitting.
// TESTING
//  1. reset=1 two cycles -> out_valid=0, out_data=FLUSH_VALUE, occupancy=0, in_ready=1 after.
//  2. out_ready=1, stream 0x1..0x8 on 8 consecutive cycles -> out_data 0x1..0x8 one cycle
//     later, back-to-back, no gaps.
//  3. (SKID_EN) accept 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held;
//     raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after first pop.
//  4. occupancy=2, assert flush with in_valid=1 in_data=0xC -> next cycle out_valid=0,
//     occupancy=0, 0xC never emitted, out_data=FLUSH_VALUE.
//  5. reset asserted while occupancy=2 and out_ready=0 -> next cycle all outputs at reset values;
//     reset together with flush behaves as reset.
//  6. (SKID_EN undefined) out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 ->
//     in_ready=1 same cycle, full throughput with random stalls, scoreboard order check.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage register.
//   pipe_state_t     : stage occupancy state (EMPTY / ONE / TWO)
//   if_id_payload_t  : default IF/ID payload layout {pc_plus_4, ir}
//   NOP_INSN         : instruction word used for bubbles (addi x0, x0, 0)
//   IF_ID_BUBBLE     : full IF/ID payload used as FLUSH_VALUE by the IF/ID instance
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] ir;
    } if_id_payload_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam if_id_payload_t IF_ID_BUBBLE = '{pc_plus_4: 32'h0000_0000, ir: NOP_INSN};

    // Number of live entries represented by a state.
    function automatic logic [1:0] state_occupancy(input pipe_state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg : parametrised valid/ready pipeline stage register with
// back-pressure, per-stage valid bit and flush-to-bubble.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   : two entries (main + skid), registered in_ready, occupancy 0..2
//   undefined : single entry, in_ready = !out_valid | out_ready, occupancy 0..1
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (wins over flush)
//   flush      in   synchronous squash of every held entry
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts in_data this cycle
//   in_data    in   upstream payload [DATA_W-1:0]
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream consumes out_data this cycle (0 = stall)
//   out_data   out  payload to next stage [DATA_W-1:0]
//   occupancy  out  entries held (0, 1 or 2)
//
// State     | meaning
// ----------+------------------------------------------------
// ST_EMPTY  | nothing held, out_valid low
// ST_ONE    | main register holds the head entry
// ST_TWO    | main holds the head, skid holds the next entry
//           | (only reachable with PIPE_STAGE_SKID_EN)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] FLUSH_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic [DATA_W-1:0] main_q;
    logic              acc;
    logic              pop;
    logic              main_load;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic              skid_load;
    logic              main_from_skid;
    logic              in_ready_q;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = in_ready_q;
`else
    // Single entry: a slot frees up in the same cycle the downstream pops.
    assign in_ready = !out_valid || out_ready;
`endif

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) state_d = ST_ONE;
            end
            ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                if (acc && !pop)      state_d = ST_TWO;
                else if (!acc && pop) state_d = ST_EMPTY;
`else
                if (!acc && pop) state_d = ST_EMPTY;
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_TWO: begin
                if (pop) state_d = ST_ONE;
            end
`endif
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        occupancy = state_occupancy(state_q);
        main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: main_load = acc;
            ST_ONE: begin
                main_load = acc && pop;
`ifdef PIPE_STAGE_SKID_EN
                skid_load = acc && !pop;
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_TWO: begin
                main_load      = pop;
                main_from_skid = 1'b1;
            end
`endif
            default: main_load = 1'b0;
        endcase
    end

    // Payload registers; they only move on an accept or a skid-to-main refill,
    // so out_data is stable for the whole of a stall.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= FLUSH_VALUE;
        end else if (main_load) begin
`ifdef PIPE_STAGE_SKID_EN
            main_q <= main_from_skid ? skid_q : in_data;
`else
            main_q <= in_data;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            skid_q <= FLUSH_VALUE;
        end else if (skid_load) begin
            skid_q <= in_data;
        end
    end

    // in_ready is precomputed from the next state so it never depends
    // combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end
`endif

endmodule
